hazard_ctrl: RTL and testbench

- Pipeline hazard and stall controller for the 5-stage core.
- Drives the hold and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Three hazard sources:
  - load-use hazards: ID needs a register that a load in EX has not yet returned;
  - taken branches resolved in EX;
  - multi-cycle data-memory accesses, via a ready handshake.
- Tracks memory-wait timeouts and keeps stall/flush performance counters.

---
 rtl/hazard_ctrl_if.sv | 44 ++++
 rtl/hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline hazard inputs and stage control outputs exchanged
// between the core datapath (master) and the hazard controller (slave).
interface hazard_ctrl_if #(
    parameter int REGADDR_WIDTH = 3,
    parameter int CNT_WIDTH     = 16
);
    logic [REGADDR_WIDTH-1:0] id_rs;
    logic [REGADDR_WIDTH-1:0] id_rt;
    logic                     id_uses_rs;
    logic                     id_uses_rt;
    logic                     ex_mem_read;
    logic                     ex_reg_write;
    logic [REGADDR_WIDTH-1:0] ex_rd;
    logic                     ex_branch_taken;
    logic                     mem_req;
    logic                     mem_ready;
    logic                     pc_write;
    logic                     if_id_write;
    logic                     if_id_flush;
    logic                     id_ex_flush;
    logic                     id_ex_hold;
    logic                     ex_mem_hold;
    logic                     mem_timeout;
    logic [CNT_WIDTH-1:0]     stall_count;
    logic [CNT_WIDTH-1:0]     flush_count;

    // Datapath side: reports hazards, consumes stage controls.
    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt,
        output ex_mem_read, ex_reg_write, ex_rd, ex_branch_taken,
        output mem_req, mem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush,
        input  id_ex_hold, ex_mem_hold, mem_timeout, stall_count, flush_count
    );

    // Controller side.
    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  ex_mem_read, ex_reg_write, ex_rd, ex_branch_taken,
        input  mem_req, mem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_flush,
        output id_ex_hold, ex_mem_hold, mem_timeout, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage core: resolves load-use,
// taken-branch and memory-wait hazards, detects memory-wait timeouts and
// keeps saturating stall/flush counters.
module hazard_ctrl #(
    parameter int REGADDR_WIDTH = 3,
    parameter int TIMEOUT       = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN, WAIT, FAULT} state_t;

    state_t               state_reg;
    logic [7:0]           wait_cnt_reg;
    logic                 mem_timeout_reg;
    logic [CNT_WIDTH-1:0] stall_count_reg;
    logic [CNT_WIDTH-1:0] flush_count_reg;

    logic freeze;
    logic load_use;
    logic mem_stall;
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic id_ex_hold;
    logic ex_mem_hold;

    assign mem_stall = hz.mem_req & ~hz.mem_ready;
    assign freeze    = mem_stall | (state_reg == FAULT);

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign load_use = hz.ex_mem_read & hz.ex_reg_write
                    & (hz.ex_rd != REGADDR_WIDTH'(0))
                    & ((hz.id_uses_rs & (hz.id_rs == hz.ex_rd))
                     | (hz.id_uses_rt & (hz.id_rt == hz.ex_rd)));

    // Prioritised stage controls: freeze > branch > load-use. While reset is
    // asserted the outputs show the quiet RUN values regardless of inputs.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        id_ex_hold  = 1'b0;
        ex_mem_hold = 1'b0;
        if (reset_n) begin
            if (freeze) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_hold  = 1'b1;
                ex_mem_hold = 1'b1;
            end else if (hz.ex_branch_taken) begin
                // A dependent instruction in ID is squashed, so load-use is moot.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    // Memory-wait FSM with timeout detection; FAULT is left only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= 8'd0;
            mem_timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (mem_stall) begin
                        state_reg    <= WAIT;
                        wait_cnt_reg <= 8'd1;
                    end
                end
                WAIT: begin
                    if (hz.mem_ready) begin
                        state_reg    <= RUN;
                        wait_cnt_reg <= 8'd0;
                    end else if (wait_cnt_reg == 8'(TIMEOUT - 1)) begin
                        state_reg       <= FAULT;
                        mem_timeout_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                FAULT: begin
                    mem_timeout_reg <= 1'b1;
                end
                default: begin
                    state_reg    <= RUN;
                    wait_cnt_reg <= 8'd0;
                end
            endcase
        end
    end

    // Saturating performance counters; they keep counting in FAULT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            if (!pc_write && (stall_count_reg != '1))
                stall_count_reg <= stall_count_reg + 1'b1;
            if (if_id_flush && (flush_count_reg != '1))
                flush_count_reg <= flush_count_reg + 1'b1;
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.if_id_write = if_id_write;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_ex_flush = id_ex_flush;
    assign hz.id_ex_hold  = id_ex_hold;
    assign hz.ex_mem_hold = ex_mem_hold;
    assign hz.mem_timeout = mem_timeout_reg;
    assign hz.stall_count = stall_count_reg;
    assign hz.flush_count = flush_count_reg;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (TIMEOUT=4). Inputs change just after the
// falling edge; controls are sampled 1ns later, counters one cycle later.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REGADDR_WIDTH(3), .CNT_WIDTH(16)) hz_bus ();

    hazard_ctrl #(.REGADDR_WIDTH(3), .TIMEOUT(4), .CNT_WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz_bus)
    );

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_hold, ex_mem_hold, mem_timeout}
    localparam logic [6:0] NORM   = 7'b1100000;
    localparam logic [6:0] LU     = 7'b0001000;
    localparam logic [6:0] BR     = 7'b1111000;
    localparam logic [6:0] FRZ    = 7'b0000110;
    localparam logic [6:0] FRZ_TO = 7'b0000111;

    function automatic logic [6:0] ctrl();
        return {hz_bus.pc_write, hz_bus.if_id_write, hz_bus.if_id_flush,
                hz_bus.id_ex_flush, hz_bus.id_ex_hold, hz_bus.ex_mem_hold,
                hz_bus.mem_timeout};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic idle_inputs();
        hz_bus.id_rs = 3'd0; hz_bus.id_rt = 3'd0;
        hz_bus.id_uses_rs = 1'b0; hz_bus.id_uses_rt = 1'b0;
        hz_bus.ex_mem_read = 1'b0; hz_bus.ex_reg_write = 1'b0;
        hz_bus.ex_rd = 3'd0; hz_bus.ex_branch_taken = 1'b0;
        hz_bus.mem_req = 1'b0; hz_bus.mem_ready = 1'b0;
    endtask

    // Check the combinational controls for the current inputs, then advance one cycle.
    task automatic step(input string tag, input logic [6:0] exp);
        #1;
        check(tag, 32'(ctrl()), 32'(exp));
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic counters(input string tag, input int stalls, input int flushes);
        check({tag, "_stall"}, 32'(hz_bus.stall_count), 32'(stalls));
        check({tag, "_flush"}, 32'(hz_bus.flush_count), 32'(flushes));
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        #1;
        check("reset_ctrl", 32'(ctrl()), 32'(NORM));
        counters("reset", 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1. Load-use on rs
        hz_bus.ex_mem_read = 1; hz_bus.ex_reg_write = 1; hz_bus.ex_rd = 3'd3;
        hz_bus.id_rs = 3'd3; hz_bus.id_uses_rs = 1;
        step("lu_stall", LU);
        hz_bus.ex_mem_read = 0;
        step("lu_after", NORM);
        counters("lu", 1, 0);

        // 2. Register-0 and unused-operand filters
        do_reset();
        hz_bus.ex_mem_read = 1; hz_bus.ex_reg_write = 1; hz_bus.ex_rd = 3'd0;
        hz_bus.id_rs = 3'd0; hz_bus.id_uses_rs = 1;
        step("r0_filter", NORM);
        hz_bus.ex_rd = 3'd5; hz_bus.id_rs = 3'd1; hz_bus.id_rt = 3'd5; hz_bus.id_uses_rt = 0;
        step("unused_rt", NORM);
        hz_bus.id_uses_rt = 1;
        step("used_rt", LU);
        counters("filter", 1, 0);

        // 3. Branch overrides load-use
        do_reset();
        hz_bus.ex_mem_read = 1; hz_bus.ex_reg_write = 1; hz_bus.ex_rd = 3'd2;
        hz_bus.id_rt = 3'd2; hz_bus.id_uses_rt = 1; hz_bus.ex_branch_taken = 1;
        step("br_over_lu", BR);
        idle_inputs();
        step("br_after", NORM);
        counters("br", 0, 1);

        // 4. Memory wait of three cycles
        do_reset();
        hz_bus.mem_req = 1; hz_bus.mem_ready = 0;
        for (int i = 0; i < 3; i++) step($sformatf("wait_frz%0d", i), FRZ);
        hz_bus.mem_ready = 1;
        step("wait_release", NORM);
        idle_inputs();
        step("wait_run", NORM);
        counters("wait", 3, 0);

        // 5. Timeout (TIMEOUT=4) and asynchronous reset out of FAULT
        do_reset();
        hz_bus.mem_req = 1; hz_bus.mem_ready = 0;
        for (int i = 0; i < 4; i++) step($sformatf("to_frz%0d", i), FRZ);
        step("to_fault", FRZ_TO);
        hz_bus.mem_ready = 1;
        step("to_ready_ignored", FRZ_TO);
        counters("to", 6, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("to_async_rst", 32'(ctrl()), 32'(NORM));
        counters("to_rst", 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        idle_inputs();

        // 6. Branch held during a memory wait
        hz_bus.mem_req = 1; hz_bus.mem_ready = 0; hz_bus.ex_branch_taken = 1;
        step("bw_frz0", FRZ);
        step("bw_frz1", FRZ);
        hz_bus.mem_ready = 1;
        step("bw_release", BR);
        idle_inputs();
        step("bw_after", NORM);
        counters("bw", 2, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
